// File: rtl/rtlpbus_arb2.sv
// rtlpbus_arb2 -- two-master round-robin sequencer for the upen/upws/uprs
// register bus. Each granted transaction issues one strobe cycle, then waits
// for uprdy (or a watchdog timeout) and returns an ack/err/rdat to its master.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN/wrN/addrN/wdatN        master N request (held until ackN)
//   ackN/errN/rdatN             master N completion pulse, timeout flag, read data
//   upen/upws/uprs/upa/updi     register bus strobe, address and write data
//   uprdy/updo                  register bus ready and read data
module rtlpbus_arb2 #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TMO_CYC = 15,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdat0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdat0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdat1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdat1,
  output logic          upen,
  output logic          upws,
  output logic          uprs,
  output logic [AW-1:0] upa,
  output logic [DW-1:0] updi,
  input  logic          uprdy,
  input  logic [DW-1:0] updo
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // cnt counts missed WAIT cycles; the TMO_CYC-th WAIT cycle without uprdy
  // is the one that times out.
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  state_t        state;
  logic          gnt;
  logic          last_gnt;
  logic          wr_q;
  logic [TW-1:0] cnt;

  logic both;
  logic nxt_gnt;
  logic nxt_wr;
  logic ack_any;

  always_comb begin
    both    = req0 & req1;
    nxt_gnt = both ? ~last_gnt : req1;
    nxt_wr  = nxt_gnt ? wr1 : wr0;
    ack_any = ack0 | ack1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      wr_q     <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      err0     <= 1'b0;
      rdat0    <= '0;
      ack1     <= 1'b0;
      err1     <= 1'b0;
      rdat1    <= '0;
      upen     <= 1'b0;
      upws     <= 1'b0;
      uprs     <= 1'b0;
      upa      <= '0;
      updi     <= '0;
    end else begin
      // strobes and completion flags are single-cycle pulses
      upen <= 1'b0;
      upws <= 1'b0;
      uprs <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle carrying an ack is a recovery cycle: the acked master
          // still shows req, and skipping it keeps strobes 4 cycles apart.
          if (!ack_any && (req0 || req1)) begin
            gnt  <= nxt_gnt;
            wr_q <= nxt_wr;
            if (both) last_gnt <= nxt_gnt;
            upa  <= nxt_gnt ? addr1 : addr0;
            updi <= nxt_gnt ? wdat1 : wdat0;
            upen <= 1'b1;
            upws <= nxt_wr;
            uprs <= ~nxt_wr;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // uprdy takes priority over a timeout landing in the same cycle
          if (uprdy) begin
            if (gnt) begin
              ack1 <= 1'b1;
              if (!wr_q) rdat1 <= updo;
            end else begin
              ack0 <= 1'b1;
              if (!wr_q) rdat0 <= updo;
            end
            state <= S_IDLE;
          end else if (cnt == TMO_LAST) begin
            if (gnt) begin
              ack1  <= 1'b1;
              err1  <= 1'b1;
              rdat1 <= '1;
            end else begin
              ack0  <= 1'b1;
              err0  <= 1'b1;
              rdat0 <= '1;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtlpbus_arb2.sv
module tb_rtlpbus_arb2;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, wr0, ack0, err0;
  logic [7:0] addr0, wdat0, rdat0;
  logic       req1, wr1, ack1, err1;
  logic [7:0] addr1, wdat1, rdat1;
  logic       upen, upws, uprs, uprdy;
  logic [7:0] upa, updi, updo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rtlpbus_arb2 #(.AW(8), .DW(8), .TMO_CYC(15), .TW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdat0(wdat0),
    .ack0(ack0), .err0(err0), .rdat0(rdat0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdat1(wdat1),
    .ack1(ack1), .err1(err1), .rdat1(rdat1),
    .upen(upen), .upws(upws), .uprs(uprs), .upa(upa), .updi(updi),
    .uprdy(uprdy), .updo(updo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs set / outputs sampled 1 time unit after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; wr0 = 0; addr0 = 0; wdat0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdat1 = 0;
    uprdy = 0; updo = 0;
    tick(2);
    chk("rst_outs", {ack0, err0, ack1, err1, upen, upws, uprs}, 7'd0);
    chk("rst_bus", {upa, updi, rdat0, rdat1}, 32'd0);
    rst = 1'b0;

    // 1: single read from master0 (T = this cycle)
    req0 = 1; wr0 = 0; addr0 = 8'h12;
    tick;                                        // T+1
    chk("rd_strobe", {upen, uprs, upws}, 3'b110);
    chk("rd_upa", upa, 8'h12);
    tick;                                        // T+2
    chk("rd_strobe_off", {upen, uprs}, 2'b00);
    uprdy = 1; updo = 8'hA5;
    tick;                                        // T+3
    uprdy = 0;
    chk("rd_ack", {ack0, err0, ack1}, 3'b100);
    chk("rd_rdat0", rdat0, 8'hA5);
    req0 = 0;
    tick;                                        // T+4
    chk("rd_ack_pulse", {ack0, err0}, 2'b00);

    // 2: single write from master1
    req1 = 1; wr1 = 1; addr1 = 8'h03; wdat1 = 8'h5C;
    tick;
    chk("wr_strobe", {upen, upws, uprs}, 3'b110);
    chk("wr_bus", {upa, updi}, {8'h03, 8'h5C});
    tick;
    uprdy = 1; updo = 8'h77;
    tick;
    uprdy = 0;
    chk("wr_ack", {ack1, err1, ack0}, 3'b100);
    chk("wr_rdat1_kept", rdat1, 8'h00);
    chk("wr_rdat0_kept", rdat0, 8'hA5);
    req1 = 0;
    tick;

    // 3: contention, both held; last_gnt=1 so grants go 0,1,0,1
    req0 = 1; wr0 = 0; addr0 = 8'h20;
    req1 = 1; wr1 = 0; addr1 = 8'h21;
    for (int i = 0; i < 4; i++) begin
      tick;                                      // T+1
      chk("ct_strobe", {upen, uprs}, 2'b11);
      chk("ct_upa", upa, (i % 2) ? 8'h21 : 8'h20);
      tick;                                      // T+2
      chk("ct_gap2", upen, 1'b0);
      uprdy = 1; updo = 8'h30 + 8'(i);
      tick;                                      // T+3
      uprdy = 0;
      chk("ct_ack", {ack1, ack0}, (i % 2) ? 2'b10 : 2'b01);
      chk("ct_gap3", upen, 1'b0);
      chk("ct_rdat", (i % 2) ? rdat1 : rdat0, 8'h30 + 8'(i));
      if (i == 3) begin
        req0 = 0; req1 = 0;
      end
      tick;                                      // T+4: IDLE grant cycle
      chk("ct_gap4", upen, 1'b0);
    end

    // 4: timeout on master0, uprdy held low
    req0 = 1; wr0 = 0; addr0 = 8'h40;
    tick;                                        // T+1
    chk("to_strobe", upen, 1'b1);
    tick(15);                                    // T+16: 15th WAIT cycle
    chk("to_no_early_ack", {ack0, ack1}, 2'b00);
    tick;                                        // T+17
    chk("to_ack", {ack0, err0, ack1, err1}, 4'b1100);
    chk("to_rdat0", rdat0, 8'hFF);
    req0 = 0;
    tick;
    chk("to_err_clr", {ack0, err0}, 2'b00);

    // 5a: uprdy on the 15th WAIT cycle wins over the timeout
    req1 = 1; wr1 = 0; addr1 = 8'h41;
    tick;
    tick(15);                                    // T+16
    uprdy = 1; updo = 8'h3C;
    tick;                                        // T+17
    uprdy = 0;
    chk("bnd_ack", {ack1, err1}, 2'b10);
    chk("bnd_rdat1", rdat1, 8'h3C);
    req1 = 0;
    tick;

    // 5b: timeout on master1, then a late uprdy is ignored
    req1 = 1; wr1 = 0; addr1 = 8'h42;
    tick(17);                                    // T+17
    chk("late_to_ack", {ack1, err1}, 2'b11);
    chk("late_to_rdat1", rdat1, 8'hFF);
    req1 = 0;
    uprdy = 1; updo = 8'h99;
    tick(2);
    uprdy = 0;
    chk("late_ignored", {ack0, ack1, upen}, 3'b000);
    chk("late_rdat1", rdat1, 8'hFF);

    // 6: reset in WAIT aborts master0; master1 granted afterwards
    req0 = 1; wr0 = 0; addr0 = 8'h50;
    req1 = 1; wr1 = 1; addr1 = 8'h51; wdat1 = 8'hAA;
    tick;                                        // T+1
    chk("rw_first_gnt", upa, 8'h50);
    tick;                                        // T+2 (WAIT)
    rst = 1; req0 = 0;
    tick;                                        // T+3
    chk("rw_outs", {ack0, err0, ack1, err1, upen, upws, uprs}, 7'd0);
    chk("rw_bus", {upa, updi, rdat0, rdat1}, 32'd0);
    rst = 0;
    tick;                                        // T+4
    chk("rw_regrant", {upen, upws, upa, updi}, {2'b11, 8'h51, 8'hAA});
    tick;
    uprdy = 1; updo = 8'h11;
    tick;
    uprdy = 0;
    chk("rw_ack1", {ack1, err1, ack0}, 3'b100);
    chk("rw_rdat1", rdat1, 8'h00);
    req1 = 0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
